// File: rtl/debounce_pkg.sv
// Shared constants, edge encoding and width helper for the debounce_bank slice.
package debounce_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 250_000;  // 10 ms at 25 MHz
    localparam int unsigned DEFAULT_HOLD_LIMIT     = 0;
    localparam int unsigned DEFAULT_SYNC_STAGES    = 2;
    localparam int unsigned SYNC_STAGES_MAX        = 3;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL
    } edge_e;

    // Bits needed to index v distinct values, never less than one.
    function automatic int unsigned clog2_w(input longint unsigned v);
        int unsigned     r;
        longint unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x != 0) begin
            r++;
            x = x >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: accepts a new level after DEBOUNCE_LIMIT steady mismatching
// samples, emits edge pulses and an optional long-press level.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned HOLD_LIMIT     = DEFAULT_HOLD_LIMIT,
    parameter logic        RESET_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sample,
    output logic level,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam int unsigned      CNT_W    = clog2_w(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             state;
    logic             state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    edge_e            edge_kind;

    // Any sample matching the current state restarts the count from zero.
    always_comb begin
        state_next = state;
        count_next = '0;
        edge_kind  = EDGE_NONE;
        if (sample != state) begin
            if (count == CNT_LAST) begin
                state_next = sample;
                edge_kind  = sample ? EDGE_RISE : EDGE_FALL;
            end else begin
                count_next = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_LEVEL;
            count <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            rise  <= (edge_kind == EDGE_RISE);
            fall  <= (edge_kind == EDGE_FALL);
        end
    end

    assign level = state;

    if (HOLD_LIMIT == 0) begin : g_no_hold
        assign hold = 1'b0;
    end else begin : g_hold
        localparam int unsigned       HOLD_W   = clog2_w(HOLD_LIMIT + 1);
        localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT);

        logic [HOLD_W-1:0] hold_cnt;

        // Clearing on every accepted edge makes hold drop on the same edge as level.
        always_ff @(posedge clk) begin
            if (rst || !state || edge_kind != EDGE_NONE) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end

        assign hold = state && (hold_cnt == HOLD_MAX);
    end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: per-bit synchroniser feeding NUM_CH independent
// debounce lanes with edge pulses and long-press detection.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned       NUM_CH         = 4,
    parameter int unsigned       DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned       HOLD_LIMIT     = DEFAULT_HOLD_LIMIT,
    parameter int unsigned       SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter logic [NUM_CH-1:0] RESET_VALUE    = '0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Switch,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Hold
);

    if (SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("debounce_bank: SYNC_STAGES out of range");
    end

    logic [NUM_CH-1:0] sampled;

    if (SYNC_STAGES == 0) begin : g_no_sync
        assign sampled = i_Switch;
    end else begin : g_sync
        logic [NUM_CH-1:0] stage [SYNC_STAGES];

        // Resetting to RESET_VALUE keeps the lanes from seeing a false edge at release.
        always_ff @(posedge i_Clk) begin
            if (i_Rst) begin
                for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                    stage[i] <= RESET_VALUE;
                end
            end else begin
                stage[0] <= i_Switch;
                for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign sampled = stage[SYNC_STAGES-1];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .HOLD_LIMIT     (HOLD_LIMIT),
            .RESET_LEVEL    (RESET_VALUE[c])
        ) u_channel (
            .clk    (i_Clk),
            .rst    (i_Rst),
            .sample (sampled[c]),
            .level  (o_Switch[c]),
            .rise   (o_Rise[c]),
            .fall   (o_Fall[c]),
            .hold   (o_Hold[c])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: expected per-cycle outputs are queued by cycle
// number as stimulus is planned and checked on the falling edge.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_in;
    logic [3:0] sw;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] hold;

    debounce_bank #(
        .NUM_CH         (4),
        .DEBOUNCE_LIMIT (4),
        .HOLD_LIMIT     (10),
        .SYNC_STAGES    (2),
        .RESET_VALUE    (4'b0000)
    ) dut (
        .i_Clk    (clk),
        .i_Rst    (rst),
        .i_Switch (sw_in),
        .o_Switch (sw),
        .o_Rise   (rise),
        .o_Fall   (fall),
        .o_Hold   (hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  sw;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  hold;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned cyc         = 0;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // cyc = number of rising edges so far; outputs at the following negedge reflect edge cyc.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_span(input int unsigned lo, input int unsigned hi,
                               input logic [3:0] s, input logic [3:0] r,
                               input logic [3:0] f, input logic [3:0] h);
        for (int unsigned c = lo; c <= hi; c++) begin
            sb.push_back('{cyc: c, sw: s, rise: r, fall: f, hold: h});
        end
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("o_Switch", sw,   e.sw);
            check("o_Rise",   rise, e.rise);
            check("o_Fall",   fall, e.fall);
            check("o_Hold",   hold, e.hold);
        end
    end

    initial begin
        // Reset held over three edges with all raw inputs high.
        rst   = 1'b1;
        sw_in = 4'hF;
        expect_span(1, 10, 4'h0, 4'h0, 4'h0, 4'h0);
        wait_cyc(3);
        rst   = 1'b0;
        sw_in = 4'h0;
        wait_cyc(10);

        // Clean step on ch0 and release; latency k+5.
        expect_span(11, 15, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_span(16, 16, 4'h1, 4'h1, 4'h0, 4'h0);
        expect_span(17, 23, 4'h1, 4'h0, 4'h0, 4'h0);
        expect_span(24, 24, 4'h0, 4'h0, 4'h1, 4'h0);
        expect_span(25, 26, 4'h0, 4'h0, 4'h0, 4'h0);
        sw_in = 4'h1;
        wait_cyc(18);
        sw_in = 4'h0;
        wait_cyc(26);

        // Three-cycle glitches on ch1 must be discarded, then a held level accepted.
        expect_span(27, 39, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_span(40, 40, 4'h2, 4'h2, 4'h0, 4'h0);
        expect_span(41, 47, 4'h2, 4'h0, 4'h0, 4'h0);
        expect_span(48, 48, 4'h0, 4'h0, 4'h2, 4'h0);
        expect_span(49, 50, 4'h0, 4'h0, 4'h0, 4'h0);
        sw_in = 4'h2;
        wait_cyc(29);
        sw_in = 4'h0;
        wait_cyc(30);
        sw_in = 4'h2;
        wait_cyc(33);
        sw_in = 4'h0;
        wait_cyc(34);
        sw_in = 4'h2;
        wait_cyc(42);
        sw_in = 4'h0;
        wait_cyc(50);

        // Long press on ch2: hold from rise+10 until the fall edge.
        expect_span(51, 55, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_span(56, 56, 4'h4, 4'h4, 4'h0, 4'h0);
        expect_span(57, 65, 4'h4, 4'h0, 4'h0, 4'h0);
        expect_span(66, 75, 4'h4, 4'h0, 4'h0, 4'h4);
        expect_span(76, 76, 4'h0, 4'h0, 4'h4, 4'h0);
        expect_span(77, 78, 4'h0, 4'h0, 4'h0, 4'h0);
        sw_in = 4'h4;
        wait_cyc(70);
        sw_in = 4'h0;
        wait_cyc(78);

        // ch0 and ch3 together.
        expect_span(79, 83, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_span(84, 84, 4'h9, 4'h9, 4'h0, 4'h0);
        expect_span(85, 91, 4'h9, 4'h0, 4'h0, 4'h0);
        expect_span(92, 92, 4'h0, 4'h0, 4'h9, 4'h0);
        expect_span(93, 94, 4'h0, 4'h0, 4'h0, 4'h0);
        sw_in = 4'h9;
        wait_cyc(86);
        sw_in = 4'h0;
        wait_cyc(94);

        // Reset while ch1 count is 2, then full latency after release;
        // finally reset with ch1 high must not emit a fall pulse.
        expect_span(95, 104, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_span(105, 105, 4'h2, 4'h2, 4'h0, 4'h0);
        expect_span(106, 107, 4'h2, 4'h0, 4'h0, 4'h0);
        expect_span(108, 112, 4'h0, 4'h0, 4'h0, 4'h0);
        sw_in = 4'h2;
        wait_cyc(98);
        rst = 1'b1;
        wait_cyc(99);
        rst = 1'b0;
        wait_cyc(107);
        rst   = 1'b1;
        sw_in = 4'h0;
        wait_cyc(109);
        rst = 1'b0;
        wait_cyc(112);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL drain observed=%0d pending expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
